midi_note_decoder: RTL and testbench
====================================

# midi_note_decoder

Serial MIDI front end for the synthesizer voice. It receives a 31250-baud MIDI stream, decodes Note On and Note Off messages for one channel, and drives the note-control inputs of the triangular ADSR voice (`freq_select`, `note_on`, `note_off`) plus velocity and gate. It is monophonic with last-note priority, and maps MIDI notes C2..B5 (36..83) onto the voice's 48-entry frequency table.

## Interface
- `CLKS_PER_BIT`, default 800: clk cycles per MIDI bit (25 MHz / 31250).
- `NOTE_BASE`, default 36: MIDI note number that maps to `freq_select` 0.
- `clk`  in  1  system clock, 25 MHz.
- `reset`  in  1  synchronous, active-low reset.
- `midi_rx`  in  1  asynchronous MIDI serial line; idles high.
- `channel`  in  4  MIDI channel to listen on (0..15).
- `freq_select`  out  6  note index, `note - NOTE_BASE`, range 0..47.
- `note_on`  out  1  one-cycle pulse on an accepted Note On.
- `note_off`  out  1  one-cycle pulse on an accepted Note Off.
- `velocity`  out  7  velocity of the last accepted Note On.
- `gate`  out  1  high while a note is held.
- `frame_err`  out  1  one-cycle pulse when a bad stop bit is seen.

## Operation
- **Reset values:** every output is 0.
- **Input sync:** `midi_rx` passes through a 2-flop synchronizer before any use.
- **RX state machine:** IDLE → START → DATA → STOP → IDLE.
  - After reset, the receiver arms only after it has sampled the line high at least once.
  - IDLE: a synchronized low starts a frame.
  - START: re-sample at `CLKS_PER_BIT/2`. If the line is high, it was a glitch; return to IDLE.
  - DATA: 8 bits, LSB first, each sampled at its bit centre.
  - STOP: line high → byte strobe. Line low → `frame_err` pulse, byte discarded, and the receiver waits for the line to go high before re-arming.
- **Parser states:** WAIT_STATUS, DATA1, DATA2.
- **Status bytes (bit7 = 1):**
  - 0x8n / 0x9n with n = `channel`: latch running status, go to DATA1.
  - Any other 0x80..0xEF, or 0xF0..0xF7: clear running status, go to WAIT_STATUS.
  - 0xF8..0xFF (realtime): ignored, parser state untouched.
- **Data bytes (bit7 = 0):** ignored in WAIT_STATUS. DATA1 stores the note and goes to DATA2. DATA2 stores velocity, executes the message, and returns to DATA1 (running status).
- **Execute:**
  - A note outside `NOTE_BASE..NOTE_BASE+47` is ignored entirely.
  - Note On with velocity > 0: `freq_select` = note − `NOTE_BASE`, `velocity` updated, `gate` = 1, `note_on` pulse. This retriggers even if a note is already held.
  - Note Off, or Note On with velocity 0: acts only if `gate` = 1 and the note equals the held note. Then `gate` = 0 and `note_off` pulse. Otherwise ignored. `freq_select` and `velocity` hold their values.
- **Arithmetic:** the note subtraction is 7-bit unsigned. The range check precedes truncation to 6 bits.

## Timing
- The synchronizer adds 2 cycles of latency.
- The byte strobe is asserted the cycle after the stop-bit sample (S+1).
- Parser outputs (`freq_select`, `velocity`, `gate`, `note_on`/`note_off`) update at S+2.
- `frame_err` pulses at S+1.
- `note_on` and `note_off` can never be asserted in the same cycle.
- Minimum spacing between pulses is one byte time (10 × `CLKS_PER_BIT`).
- Reset mid-frame or mid-message: RX and parser go idle, running status is cleared, and all outputs return to 0 on the next edge.
- The bit-timing counter is wide enough for `CLKS_PER_BIT` ≤ 65535.

## Configuration
- `MIDI_OMNI_EN` defined: the `channel` input is ignored, and Note On/Off on all 16 channels is accepted.
- Undefined: only messages on `channel` are accepted.

## Structure
- Package `midi_pkg` holds:
  - status nibble constants: `NOTE_OFF` = 4'h8, `NOTE_ON` = 4'h9, and the realtime/system thresholds;
  - RX and parser state enumerations;
  - the default `NOTE_BASE` and the note-range width (48).
- Sub-module `midi_uart_rx` contains the synchronizer, bit timing and framing. It outputs `byte_valid`, `byte_data[7:0]` and `frame_err`.
- The parser and output registers live in the top level.

## Test plan
1. **Basic Note On.** `channel`=0; send 0x90 0x45 0x64 → one `note_on` pulse, `freq_select`=33, `velocity`=100, `gate`=1, at S+2 of the last byte.
2. **Running status.** Send 0x90 0x3C 0x40 0x3E 0x40 → two `note_on` pulses; `freq_select` 24, then 26; `gate` stays 1.
3. **Note Off.** After case 1:
   - send 0x45 0x00 → `note_off` pulse, `gate`=0;
   - hold note 0x3C, then send 0x80 0x3E 0x40 → no pulse, `gate` stays 1.
4. **Range and channel filtering.**
   - 0x90 0x23 0x40 and 0x90 0x54 0x40 → no outputs change.
   - 0x91 0x45 0x64 with `channel`=0 → ignored.
   - 0x91 0x45 0x64 with `MIDI_OMNI_EN` defined → `note_on`, `freq_select`=33.
5. **Realtime interleave.** 0x90 0xF8 0x45 0xFE 0x64 → decoded as Note On 0x45, velocity 100.
6. **Errors and reset.**
   - A byte with its stop bit low → `frame_err` pulse, byte dropped, parser state unchanged.
   - `reset` low mid-byte → all outputs 0.
   - A following valid 0x90 0x45 0x64 decodes correctly.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI note decoder.
//   - status nibble constants and the realtime threshold
//   - RX framing and message parser state enumerations
//   - default note base and the size of the voice's note table
//   - note_in_range(): range check done on the full 7-bit note
package midi_pkg;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [7:0] SYS_REALTIME  = 8'hF8;  // 0xF8..0xFF never disturb the parser
  localparam logic [7:0] SYS_COMMON    = 8'hF0;  // 0xF0..0xF7 cancel running status

  localparam int NOTE_BASE_DEF = 36;
  localparam int NOTE_RANGE    = 48;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_DATA1,
    P_DATA2
  } parse_state_t;

  function automatic logic note_in_range(input logic [6:0] note, input int base);
    int n;
    n = int'(note);
    return (n >= base) && (n < base + NOTE_RANGE);
  endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// midi_note_decoder_if: note-control bundle from the MIDI decoder to the voice.
//   freq_select [5:0]  note index into the 48-entry frequency table
//   note_on            one-cycle pulse on an accepted Note On
//   note_off           one-cycle pulse on an accepted Note Off
//   velocity    [6:0]  velocity of the last accepted Note On
//   gate               high while a note is held
//   frame_err          one-cycle pulse on a bad stop bit
// Modports: master (decoder side, drives), slave (voice side, receives).
interface midi_note_decoder_if;
  logic [5:0] freq_select;
  logic       note_on;
  logic       note_off;
  logic [6:0] velocity;
  logic       gate;
  logic       frame_err;

  modport master (output freq_select, note_on, note_off, velocity, gate, frame_err);
  modport slave  (input  freq_select, note_on, note_off, velocity, gate, frame_err);
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver for the MIDI line.
//   clk, reset (sync, active-low)
//   midi_rx     asynchronous serial input, idles high
//   byte_valid  one-cycle strobe, the cycle after the stop-bit sample
//   byte_data   received byte, stable until the next frame's data bits
//   frame_err   one-cycle pulse, the cycle after a low stop-bit sample
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_sync_p0, rx_sync_p1;
  logic        rx;
  rx_state_t   state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic        armed;        // set once the line has been seen high; cleared on a framing error
  logic [7:0]  shift_r;
  logic        half_done, full_done;

  assign rx        = rx_sync_p1;
  assign half_done = (cnt == HALF_M1);
  assign full_done = (cnt == FULL_M1);
  assign byte_data = shift_r;

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (armed && !rx)                  state_nxt = RX_START;
      RX_START: if (half_done)                     state_nxt = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_done && bit_idx == 3'd7)  state_nxt = RX_STOP;
      RX_STOP:  if (full_done)                     state_nxt = RX_IDLE;
      default:                                     state_nxt = RX_IDLE;
    endcase
  end

  // stage p0/p1: two-flop synchronizer, then framing control
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_sync_p0 <= 1'b0;
      rx_sync_p1 <= 1'b0;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      armed      <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_sync_p0 <= midi_rx;
      rx_sync_p1 <= rx_sync_p0;
      state      <= state_nxt;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx) armed <= 1'b1;
        end
        RX_START: cnt <= half_done ? 16'd0 : cnt + 16'd1;
        RX_DATA: begin
          cnt <= full_done ? 16'd0 : cnt + 16'd1;
          if (full_done) bit_idx <= bit_idx + 3'd1;
        end
        RX_STOP: begin
          cnt <= full_done ? 16'd0 : cnt + 16'd1;
          if (full_done) begin
            if (rx) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // data bits arrive LSB first, so shift in from the top
  always_ff @(posedge clk) begin
    if (state == RX_DATA && full_done) shift_r <= {rx, shift_r[7:1]};
  end

endmodule

// File: rtl/midi_note_decoder.sv
// midi_note_decoder: monophonic, last-note-priority MIDI Note On/Off decoder.
//   clk, reset (sync, active-low)
//   midi_rx   asynchronous MIDI serial line
//   channel   MIDI channel to listen on
//   note_if   master side of midi_note_decoder_if (freq_select, note_on,
//             note_off, velocity, gate, frame_err)
// Build option: define MIDI_OMNI_EN to accept Note On/Off on every channel.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 800,
  parameter int NOTE_BASE    = NOTE_BASE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                midi_rx,
  input  logic [3:0]          channel,
  midi_note_decoder_if.master note_if
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .midi_rx    (midi_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  parse_state_t p_state, p_state_nxt;
  logic         rs_on, rs_on_nxt;      // running status: 1 = Note On, 0 = Note Off
  logic [6:0]   note_r, note_nxt;
  logic [5:0]   fsel_r, fsel_nxt;
  logic [6:0]   vel_r, vel_nxt;
  logic         gate_r, gate_nxt;
  logic         on_r, on_nxt;
  logic         off_r, off_nxt;

  logic         chan_ok;
  logic         note_status;
  logic [6:0]   note_rel;

`ifdef MIDI_OMNI_EN
  assign chan_ok = 1'b1;
`else
  assign chan_ok = (byte_data[3:0] == channel);
`endif

  assign note_status = (byte_data[7:4] == NOTE_OFF) || (byte_data[7:4] == NOTE_ON);
  // 7-bit subtraction; only its low 6 bits are used, and only after the range check passes
  assign note_rel    = note_r - 7'(NOTE_BASE);

  always_comb begin
    p_state_nxt = p_state;
    rs_on_nxt   = rs_on;
    note_nxt    = note_r;
    fsel_nxt    = fsel_r;
    vel_nxt     = vel_r;
    gate_nxt    = gate_r;
    on_nxt      = 1'b0;
    off_nxt     = 1'b0;
    if (byte_valid) begin
      if (byte_data[7]) begin
        if (byte_data >= SYS_REALTIME) begin
          p_state_nxt = p_state;
        end else if (byte_data < SYS_COMMON && note_status && chan_ok) begin
          rs_on_nxt   = byte_data[4];
          p_state_nxt = P_DATA1;
        end else begin
          rs_on_nxt   = 1'b0;
          p_state_nxt = P_WAIT_STATUS;
        end
      end else begin
        case (p_state)
          P_DATA1: begin
            note_nxt    = byte_data[6:0];
            p_state_nxt = P_DATA2;
          end
          P_DATA2: begin
            p_state_nxt = P_DATA1;
            if (note_in_range(note_r, NOTE_BASE)) begin
              if (rs_on && byte_data[6:0] != 7'd0) begin
                fsel_nxt = note_rel[5:0];
                vel_nxt  = byte_data[6:0];
                gate_nxt = 1'b1;
                on_nxt   = 1'b1;
              end else if (gate_r && note_rel[5:0] == fsel_r) begin
                gate_nxt = 1'b0;
                off_nxt  = 1'b1;
              end
            end
          end
          default: p_state_nxt = p_state;
        endcase
      end
    end
  end

  // stage p2: parser state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_state <= P_WAIT_STATUS;
      rs_on   <= 1'b0;
      fsel_r  <= '0;
      vel_r   <= '0;
      gate_r  <= 1'b0;
      on_r    <= 1'b0;
      off_r   <= 1'b0;
    end else begin
      p_state <= p_state_nxt;
      rs_on   <= rs_on_nxt;
      fsel_r  <= fsel_nxt;
      vel_r   <= vel_nxt;
      gate_r  <= gate_nxt;
      on_r    <= on_nxt;
      off_r   <= off_nxt;
    end
  end

  always_ff @(posedge clk) begin
    note_r <= note_nxt;
  end

  assign note_if.freq_select = fsel_r;
  assign note_if.velocity    = vel_r;
  assign note_if.gate        = gate_r;
  assign note_if.note_on     = on_r;
  assign note_if.note_off    = off_r;
  assign note_if.frame_err   = frame_err;

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: directed bench for midi_note_decoder with a short bit time.
module tb_midi_note_decoder;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       midi_rx = 1'b1;
  logic [3:0] channel = 4'd0;

  midi_note_decoder_if nif ();

  midi_note_decoder #(.CLKS_PER_BIT(CPB), .NOTE_BASE(36)) dut (
    .clk     (clk),
    .reset   (reset),
    .midi_rx (midi_rx),
    .channel (channel),
    .note_if (nif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int on_cnt = 0, off_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  int on0, off0, ferr0;

  always @(negedge clk) begin
    if (nif.note_on)                 on_cnt++;
    if (nif.note_off)                off_cnt++;
    if (nif.frame_err)               ferr_cnt++;
    if (nif.note_on && nif.note_off) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    midi_rx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
    midi_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic snap();
    on0 = on_cnt; off0 = off_cnt; ferr0 = ferr_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_fsel", nif.freq_select, 0);
    chk("rst_vel", nif.velocity, 0);
    chk("rst_gate", nif.gate, 0);
    chk("rst_on", nif.note_on, 0);
    chk("rst_off", nif.note_off, 0);
    chk("rst_ferr", nif.frame_err, 0);
    reset = 1'b1;
    repeat (3 * CPB) @(posedge clk);

    // basic Note On
    snap();
    send_byte(8'h90, 1); send_byte(8'h45, 1); send_byte(8'h64, 1);
    @(negedge clk);
    chk("t1_on", on_cnt - on0, 1);
    chk("t1_fsel", nif.freq_select, 33);
    chk("t1_vel", nif.velocity, 100);
    chk("t1_gate", nif.gate, 1);

    // Note On velocity 0 on held note via running status
    snap();
    send_byte(8'h45, 1); send_byte(8'h00, 1);
    @(negedge clk);
    chk("t3a_off", off_cnt - off0, 1);
    chk("t3a_gate", nif.gate, 0);
    chk("t3a_fsel", nif.freq_select, 33);
    chk("t3a_vel", nif.velocity, 100);

    // running status, two notes
    snap();
    send_byte(8'h90, 1); send_byte(8'h3C, 1); send_byte(8'h40, 1);
    send_byte(8'h3E, 1); send_byte(8'h40, 1);
    @(negedge clk);
    chk("t2_on", on_cnt - on0, 2);
    chk("t2_fsel", nif.freq_select, 26);
    chk("t2_gate", nif.gate, 1);
    chk("t2_vel", nif.velocity, 64);

    // hold 0x3C, Note Off for a different note is ignored
    send_byte(8'h3C, 1); send_byte(8'h50, 1);
    @(negedge clk);
    chk("t3b_fsel", nif.freq_select, 24);
    chk("t3b_vel", nif.velocity, 80);
    snap();
    send_byte(8'h80, 1); send_byte(8'h3E, 1); send_byte(8'h40, 1);
    @(negedge clk);
    chk("t3b_nooff", off_cnt - off0, 0);
    chk("t3b_gate", nif.gate, 1);
    // Note Off for the held note under running status 0x80
    send_byte(8'h3C, 1); send_byte(8'h00, 1);
    @(negedge clk);
    chk("t3c_off", off_cnt - off0, 1);
    chk("t3c_gate", nif.gate, 0);
    chk("t3c_fsel", nif.freq_select, 24);

    // out-of-range notes 35 and 84
    snap();
    send_byte(8'h90, 1); send_byte(8'h23, 1); send_byte(8'h40, 1);
    send_byte(8'h90, 1); send_byte(8'h54, 1); send_byte(8'h40, 1);
    @(negedge clk);
    chk("t4_range_on", on_cnt - on0, 0);
    chk("t4_range_fsel", nif.freq_select, 24);
    chk("t4_range_gate", nif.gate, 0);

    // other channel
    snap();
    send_byte(8'h91, 1); send_byte(8'h45, 1); send_byte(8'h64, 1);
    @(negedge clk);
`ifdef MIDI_OMNI_EN
    chk("t4_ch1_on", on_cnt - on0, 1);
    chk("t4_ch1_fsel", nif.freq_select, 33);
`else
    chk("t4_ch1_on", on_cnt - on0, 0);
    chk("t4_ch1_fsel", nif.freq_select, 24);
`endif
    send_byte(8'h80, 1); send_byte(8'h45, 1); send_byte(8'h00, 1);
    @(negedge clk);
    chk("t4_ch1_gate", nif.gate, 0);

    // listening on channel 1 accepts 0x91
    channel = 4'd1;
    snap();
    send_byte(8'h91, 1); send_byte(8'h2A, 1); send_byte(8'h7F, 1);
    @(negedge clk);
    chk("t4_sel_on", on_cnt - on0, 1);
    chk("t4_sel_fsel", nif.freq_select, 6);
    chk("t4_sel_vel", nif.velocity, 127);
    channel = 4'd0;

    // realtime bytes interleaved
    snap();
    send_byte(8'h90, 1); send_byte(8'hF8, 1); send_byte(8'h45, 1);
    send_byte(8'hFE, 1); send_byte(8'h64, 1);
    @(negedge clk);
    chk("t5_on", on_cnt - on0, 1);
    chk("t5_fsel", nif.freq_select, 33);
    chk("t5_vel", nif.velocity, 100);

    // range edges 36 and 83
    send_byte(8'h24, 1); send_byte(8'h01, 1);
    @(negedge clk);
    chk("edge_lo_fsel", nif.freq_select, 0);
    send_byte(8'h53, 1); send_byte(8'h01, 1);
    @(negedge clk);
    chk("edge_hi_fsel", nif.freq_select, 47);

    // bad stop bit: byte dropped, parser still expects a note
    snap();
    send_byte(8'h3C, 0);
    send_byte(8'h30, 1); send_byte(8'h22, 1);
    @(negedge clk);
    chk("t6_ferr", ferr_cnt - ferr0, 1);
    chk("t6_fsel", nif.freq_select, 12);
    chk("t6_vel", nif.velocity, 34);

    // reset mid-byte
    midi_rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_gate", nif.gate, 0);
    chk("t6_rst_fsel", nif.freq_select, 0);
    chk("t6_rst_vel", nif.velocity, 0);
    midi_rx = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    repeat (3 * CPB) @(posedge clk);

    // running status cleared by reset
    snap();
    send_byte(8'h45, 1); send_byte(8'h64, 1);
    @(negedge clk);
    chk("t6_norun_on", on_cnt - on0, 0);
    send_byte(8'h90, 1); send_byte(8'h45, 1); send_byte(8'h64, 1);
    @(negedge clk);
    chk("t6_after_on", on_cnt - on0, 1);
    chk("t6_after_fsel", nif.freq_select, 33);
    chk("t6_after_vel", nif.velocity, 100);
    chk("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
